pdm_mic_receiver: RTL and testbench

//  Capture path, the counterpart of the Audio PWM output stage. Drives the on-board PDM

---
 rtl/pdm_mic_receiver.sv | 157 +++++++++++++++
 tb/tb_pdm_mic_receiver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_receiver.sv
// pdm_mic_receiver: drives the PDM microphone clock, synchronises and samples the
// 1-bit PDM stream on each M_CLK falling edge, and decimates it with a boxcar
// ones-counter into 8-bit unsigned samples (128 = silence).
// Optional feature macro: PDM_RX_AVG2_EN adds a two-window averaging stage
// (output = (current + previous) >> 1, previous preloaded with 8'h80).
module pdm_mic_receiver #(
  parameter int CLK_HALF   = 20,
  parameter int DECIM_LOG2 = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       M_DATA,
  output logic       M_CLK,
  output logic       M_LRSEL,
  output logic [7:0] sample_out,
  output logic       sample_valid
);

  localparam int                    AW       = DECIM_LOG2 + 1;
  localparam logic [7:0]            DIV_LAST = 8'(CLK_HALF - 1);
  localparam logic [DECIM_LOG2-1:0] BIT_LAST = {DECIM_LOG2{1'b1}};
  localparam logic [7:0]            SILENCE  = 8'h80;

  // Clamp a 9-bit scaled count into the 8-bit sample range (all-ones gives 255).
  function automatic logic [7:0] saturate8(input logic [8:0] v);
    logic [7:0] r;
    if (v > 9'd255) begin
      r = 8'hFF;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  logic                  d_s1_r;
  logic                  d_s2_r;
  logic [7:0]            div_cnt_r;
  logic                  m_clk_r;
  logic [DECIM_LOG2-1:0] bit_cnt_r;
  logic [AW-1:0]         acc_r;
  logic [7:0]            sample_r;
  logic                  valid_r;

  logic                  div_wrap_s;
  logic                  capture_s;
  logic                  window_end_s;
  logic [8:0]            total_s;
  logic [8:0]            scaled_s;
  logic [7:0]            window_s;
  logic [7:0]            next_sample_s;

`ifdef PDM_RX_AVG2_EN
  logic [7:0]            prev_r;
  logic [8:0]            avg_sum_s;
`endif

  // Capture strobe, window-end detection and the value of the closing window.
  always_comb begin
    div_wrap_s   = (div_cnt_r == DIV_LAST);
    // The high phase ends when the divider wraps while M_CLK is high.
    capture_s    = enable && div_wrap_s && m_clk_r;
    window_end_s = capture_s && (bit_cnt_r == BIT_LAST);
    total_s      = 9'(acc_r) + 9'(d_s2_r);
    scaled_s     = total_s << (8 - DECIM_LOG2);
    window_s     = saturate8(scaled_s);
`ifdef PDM_RX_AVG2_EN
    avg_sum_s     = {1'b0, window_s} + {1'b0, prev_r};
    next_sample_s = 8'(avg_sum_s >> 1);
`else
    next_sample_s = window_s;
`endif
  end

  // Two-flop synchroniser for the asynchronous PDM data line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_s1_r <= 1'b0;
      d_s2_r <= 1'b0;
    end else begin
      d_s1_r <= M_DATA;
      d_s2_r <= d_s1_r;
    end
  end

  // Microphone clock divider: toggle M_CLK every CLK_HALF cycles while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= 8'd0;
      m_clk_r   <= 1'b0;
    end else if (!enable) begin
      div_cnt_r <= 8'd0;
      m_clk_r   <= 1'b0;
    end else if (div_wrap_s) begin
      div_cnt_r <= 8'd0;
      m_clk_r   <= ~m_clk_r;
    end else begin
      div_cnt_r <= div_cnt_r + 8'd1;
    end
  end

  // Boxcar window: count captures and captured ones; restart after each window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= {DECIM_LOG2{1'b0}};
      acc_r     <= {AW{1'b0}};
    end else if (!enable) begin
      bit_cnt_r <= {DECIM_LOG2{1'b0}};
      acc_r     <= {AW{1'b0}};
    end else if (window_end_s) begin
      bit_cnt_r <= {DECIM_LOG2{1'b0}};
      acc_r     <= {AW{1'b0}};
    end else if (capture_s) begin
      bit_cnt_r <= bit_cnt_r + DECIM_LOG2'(1);
      acc_r     <= acc_r + AW'(d_s2_r);
    end else begin
      bit_cnt_r <= bit_cnt_r;
      acc_r     <= acc_r;
    end
  end

`ifdef PDM_RX_AVG2_EN
  // Previous window value for the second averaging stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= SILENCE;
    end else if (!enable) begin
      prev_r <= SILENCE;
    end else if (window_end_s) begin
      prev_r <= window_s;
    end else begin
      prev_r <= prev_r;
    end
  end
`endif

  // Registered sample output and its one-cycle valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_r <= SILENCE;
      valid_r  <= 1'b0;
    end else begin
      valid_r <= window_end_s;
      if (window_end_s) begin
        sample_r <= next_sample_s;
      end else begin
        sample_r <= sample_r;
      end
    end
  end

  assign M_CLK        = m_clk_r;
  assign M_LRSEL      = 1'b0;
  assign sample_out   = sample_r;
  assign sample_valid = valid_r;

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// Testbench for pdm_mic_receiver (CLK_HALF=4, DECIM_LOG2=4). A cycle-level model
// derived from edge counts predicts M_CLK, the strobe and the sample value; directed
// windows add hand-computed literal expectations. Honours PDM_RX_AVG2_EN.
module tb_pdm_mic_receiver;

  localparam int CH = 4;
  localparam int DL = 4;
  localparam int NB = 1 << DL;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       enable = 1'b0;
  logic       M_DATA = 1'b0;
  logic       M_CLK;
  logic       M_LRSEL;
  logic [7:0] sample_out;
  logic       sample_valid;

  int vectors     = 0;
  int miscompares = 0;
  int mode        = 0;
  int cyc         = 0;

  pdm_mic_receiver #(.CLK_HALF(CH), .DECIM_LOG2(DL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .M_DATA       (M_DATA),
    .M_CLK        (M_CLK),
    .M_LRSEL      (M_LRSEL),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Pattern generator: M_DATA changes only on falling clk edges.
  // mode 0: zeros, 1: ones, 2: alternate per mic period, 3: one in four periods.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      case (mode)
        1:       M_DATA = 1'b1;
        2:       M_DATA = ((cyc / (2 * CH)) % 2) == 1;
        3:       M_DATA = ((cyc / (2 * CH)) % 4) == 0;
        default: M_DATA = 1'b0;
      endcase
    end
  end

  // Reference model: n counts consecutive enabled edges; M_CLK = (n/CH) odd,
  // a bit is captured every 2*CH enabled edges (data seen two edges earlier),
  // and every NB captures a sample is produced.
  int n, ones, caps, h1, h2, cap_bit, cur, prev;
  int exp_mclk, exp_out, exp_valid;
  initial begin
    n = 0; ones = 0; caps = 0; h1 = 0; h2 = 0; prev = 128;
    exp_mclk = 0; exp_out = 128; exp_valid = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        n = 0; ones = 0; caps = 0; h1 = 0; h2 = 0; prev = 128;
        exp_mclk = 0; exp_out = 128; exp_valid = 0;
      end else begin
        cap_bit   = h2;
        h2        = h1;
        h1        = int'(M_DATA);
        exp_valid = 0;
        if (enable) begin
          n++;
          exp_mclk = ((n / CH) % 2);
          if (n % (2 * CH) == 0) begin
            ones += cap_bit;
            caps++;
            if (caps == NB) begin
              cur = ones * (256 / NB);
              if (cur > 255) cur = 255;
`ifdef PDM_RX_AVG2_EN
              exp_out = (cur + prev) / 2;
              prev    = cur;
`else
              exp_out = cur;
`endif
              exp_valid = 1;
              ones = 0;
              caps = 0;
            end
          end
        end else begin
          n = 0; ones = 0; caps = 0; prev = 128;
          exp_mclk = 0;
        end
      end
      #1;
      chk("model_m_clk", int'(M_CLK), exp_mclk);
      chk("model_valid", int'(sample_valid), exp_valid);
      chk("model_sample", int'(sample_out), exp_out);
      chk("model_lrsel", int'(M_LRSEL), 0);
    end
  end

  // Wait (bounded) for the next strobe; returns the number of edges waited.
  task automatic wait_strobe(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (sample_valid) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL strobe_timeout: actual none required strobe within 400 cycles");
    end
  endtask

  // Let one window absorb the pattern change, then check the steady window.
  task automatic steady_window(input string name, input int m, input int req);
    int c;
    mode = m;
    wait_strobe(c);
    wait_strobe(c);
    chk({name, "_interval"}, c, 128);
    chk({name, "_value"}, int'(sample_out), req);
  endtask

  initial begin
    int cycles;
    int seen;

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (sample_valid) seen++;
    end
    chk("idle_strobes", seen, 0);
    chk("idle_m_clk", int'(M_CLK), 0);
    chk("idle_sample", int'(sample_out), 128);
    chk("idle_lrsel", int'(M_LRSEL), 0);

    // Clock generation: first rise CH edges after enable, period 2*CH.
    @(negedge clk);
    mode   = 1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("mclk_before_rise", int'(M_CLK), 0);
    @(posedge clk);
    #1 chk("mclk_first_rise", int'(M_CLK), 1);
    repeat (3) @(posedge clk);
    #1 chk("mclk_still_high", int'(M_CLK), 1);
    @(posedge clk);
    #1 chk("mclk_first_fall", int'(M_CLK), 0);

    // Saturation, silence and partial densities.
    steady_window("all_ones", 1, 255);
    steady_window("all_zeros", 0, 0);
    steady_window("alternate", 2, 128);
    steady_window("quarter", 3, 64);

    // Enable dropped after 10 captures: partial window discarded.
    seen = 0;
    for (int i = 0; i < 10 * 2 * CH; i++) begin
      @(posedge clk);
      #1;
      if (sample_valid) seen++;
    end
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (sample_valid) seen++;
    end
    chk("partial_strobes", seen, 0);
    chk("disabled_m_clk", int'(M_CLK), 0);
    chk("disabled_hold", int'(sample_out), 64);
    @(negedge clk);
    enable = 1'b1;
    wait_strobe(cycles);
    chk("restart_latency", cycles, 128);

    // Reset mid-window.
    mode = 1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_m_clk", int'(M_CLK), 0);
    chk("rst_sample", int'(sample_out), 128);
    chk("rst_valid", int'(sample_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_strobe(cycles);
    chk("post_reset_latency", cycles, 128);
`ifdef PDM_RX_AVG2_EN
    chk("avg_ones_after_preload", int'(sample_out), 191);
`else
    chk("ones_after_reset", int'(sample_out), 255);
`endif
    mode = 0;
    wait_strobe(cycles);
    chk("zeros_interval", cycles, 128);
`ifdef PDM_RX_AVG2_EN
    chk("avg_zeros_after_ones", int'(sample_out), 127);
`else
    chk("zeros_after_ones", int'(sample_out), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
